// File: rtl/ms_burst_master_pkg.sv
// Shared types and default sizes for the burst master.
package ms_burst_pkg;
   localparam int AW_D    = 8;
   localparam int DW_D    = 16;
   localparam int LW_D    = 8;
   localparam int SCALE_D = 4;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
   typedef enum logic [1:0] {PAT_SCALE, PAT_SEQ, PAT_INV, PAT_RSVD} mode_t;
endpackage

// File: rtl/ms_burst_master_if.sv
// Config, beat handshake and status bundle between controller, master and slave.
// MS_BURST_STALL_TIMEOUT_EN adds the timeout status bit.
interface ms_burst_master_if
   import ms_burst_pkg::*;
#(
   parameter int AW = AW_D,
   parameter int DW = DW_D,
   parameter int LW = LW_D
);
   logic          start;
   logic [AW-1:0] cfg_base;
   logic [AW-1:0] cfg_stride;
   logic [LW-1:0] cfg_len;
   mode_t         cfg_mode;
   logic [DW-1:0] cfg_seed;
   logic          valid;
   logic          sready;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          busy;
   logic          done;
`ifdef MS_BURST_STALL_TIMEOUT_EN
   logic          timeout;

   modport master (input start, cfg_base, cfg_stride, cfg_len, cfg_mode, cfg_seed, sready,
                   output valid, addr, data, busy, done, timeout);
   modport slave  (output start, cfg_base, cfg_stride, cfg_len, cfg_mode, cfg_seed, sready,
                   input valid, addr, data, busy, done, timeout);
`else
   modport master (input start, cfg_base, cfg_stride, cfg_len, cfg_mode, cfg_seed, sready,
                   output valid, addr, data, busy, done);
   modport slave  (output start, cfg_base, cfg_stride, cfg_len, cfg_mode, cfg_seed, sready,
                   input valid, addr, data, busy, done);
`endif
endinterface

// File: rtl/ms_burst_master_pattern_gen.sv
// Combinational beat-data generator; all results truncated to DW.
module ms_pattern_gen
   import ms_burst_pkg::*;
#(
   parameter int AW    = AW_D,
   parameter int DW    = DW_D,
   parameter int LW    = LW_D,
   parameter int SCALE = SCALE_D
) (
   input  mode_t         i_mode,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_seed,
   input  logic [LW-1:0] i_beat,
   output logic [DW-1:0] o_data
);
   logic [DW-1:0] w_addr_ext;
   assign w_addr_ext = DW'(i_addr);

   always_comb begin
      o_data = w_addr_ext * DW'(SCALE);
      case (i_mode)
         PAT_SEQ: o_data = i_seed + DW'(i_beat);
         PAT_INV: o_data = ~w_addr_ext;
         default: o_data = w_addr_ext * DW'(SCALE);
      endcase
   end
endmodule

// File: rtl/ms_burst_master.sv
// Programmable address/data burst master over a valid/ready handshake.
// Optional stall abort: MS_BURST_STALL_TIMEOUT_EN.
module ms_burst_master
   import ms_burst_pkg::*;
#(
   parameter int AW    = AW_D,
   parameter int DW    = DW_D,
   parameter int LW    = LW_D,
   parameter int SCALE = SCALE_D
`ifdef MS_BURST_STALL_TIMEOUT_EN
  ,parameter int TO_CYC = 16
`endif
) (
   input logic               clk,
   input logic               rstn,
   ms_burst_master_if.master bus
);
   state_t        r_state;
   logic [AW-1:0] r_stride, r_addr;
   logic [LW-1:0] r_len, r_beat;
   mode_t         r_mode;
   logic [DW-1:0] r_seed, r_data;
   logic          r_valid, r_busy, r_done;
`ifdef MS_BURST_STALL_TIMEOUT_EN
   localparam int SW = $clog2(TO_CYC + 1);
   logic [SW-1:0] r_stall;
   logic          r_timeout;
   assign bus.timeout = r_timeout;
`endif

   logic          w_xfer, w_last;
   logic [AW-1:0] w_nxt_addr;
   logic [LW-1:0] w_nxt_beat;
   mode_t         w_pat_mode;
   logic [AW-1:0] w_pat_addr;
   logic [DW-1:0] w_pat_seed, w_pat_data;
   logic [LW-1:0] w_pat_beat;

   assign w_xfer     = r_valid && bus.sready;
   assign w_last     = (r_beat == r_len - LW'(1));
   assign w_nxt_addr = r_addr + r_stride;
   assign w_nxt_beat = r_beat + LW'(1);

   // In IDLE the generator sees the live config (beat 0); afterwards the next beat.
   always_comb begin
      w_pat_mode = r_mode;
      w_pat_addr = w_nxt_addr;
      w_pat_seed = r_seed;
      w_pat_beat = w_nxt_beat;
      if (r_state == IDLE) begin
         w_pat_mode = bus.cfg_mode;
         w_pat_addr = bus.cfg_base;
         w_pat_seed = bus.cfg_seed;
         w_pat_beat = '0;
      end
   end

   ms_pattern_gen #(.AW(AW), .DW(DW), .LW(LW), .SCALE(SCALE)) u_pat (
      .i_mode (w_pat_mode),
      .i_addr (w_pat_addr),
      .i_seed (w_pat_seed),
      .i_beat (w_pat_beat),
      .o_data (w_pat_data)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_stride <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_beat   <= '0;
         r_mode   <= PAT_SCALE;
         r_seed   <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef MS_BURST_STALL_TIMEOUT_EN
         r_stall   <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_stride <= bus.cfg_stride;
                  r_len    <= bus.cfg_len;
                  r_mode   <= bus.cfg_mode;
                  r_seed   <= bus.cfg_seed;
                  r_beat   <= '0;
`ifdef MS_BURST_STALL_TIMEOUT_EN
                  r_stall  <= '0;
`endif
                  if (bus.cfg_len != '0) begin
                     r_state <= RUN;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b1;
                     r_addr  <= bus.cfg_base;
                     r_data  <= w_pat_data;
                  end else begin
                     r_state <= FINISH;
                     r_done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_xfer) begin
`ifdef MS_BURST_STALL_TIMEOUT_EN
                  r_stall <= '0;
`endif
                  if (w_last) begin
                     r_state <= FINISH;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_addr <= w_nxt_addr;
                     r_data <= w_pat_data;
                     r_beat <= w_nxt_beat;
                  end
               end
`ifdef MS_BURST_STALL_TIMEOUT_EN
               // valid is always high in RUN, so no transfer means a stall cycle
               else if (r_stall == SW'(TO_CYC - 1)) begin
                  r_state   <= FINISH;
                  r_valid   <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end else begin
                  r_stall <= r_stall + SW'(1);
               end
`endif
            end
            FINISH: begin
               r_done  <= 1'b0;
`ifdef MS_BURST_STALL_TIMEOUT_EN
               r_timeout <= 1'b0;
`endif
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.valid = r_valid;
   assign bus.addr  = r_addr;
   assign bus.data  = r_data;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
endmodule

// File: tb/tb_ms_burst_master.sv
// Randomised self-checking bench for ms_burst_master against a beat-list reference model.
module tb_ms_burst_master;
   import ms_burst_pkg::*;
   localparam int AW = 8, DW = 16, LW = 8, SCALE = 4;
`ifdef MS_BURST_STALL_TIMEOUT_EN
   localparam int TO_CYC = 16;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   ms_burst_master_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

   ms_burst_master #(.AW(AW), .DW(DW), .LW(LW), .SCALE(SCALE)
`ifdef MS_BURST_STALL_TIMEOUT_EN
      , .TO_CYC(TO_CYC)
`endif
   ) dut (.clk(clk), .rstn(rstn), .bus(bus));

   int n_chk = 0, n_fail = 0;
   logic [AW-1:0] obs_a[$];
   logic [DW-1:0] obs_d[$];
   int  stall_bad, busy_bad, done_lat, first_v, first_x, last_x, vld_cycles;
   bit  done_seen, to_seen;

   // Reference: beat i of a burst, straight from the address/pattern rules.
   function automatic logic [AW-1:0] ref_addr(int unsigned base, int unsigned stride, int unsigned i);
      int unsigned v;
      v = base + i * stride;
      return v[AW-1:0];
   endfunction

   function automatic logic [DW-1:0] ref_data(int mode, int unsigned a, int unsigned seed, int unsigned i);
      int unsigned v;
      case (mode)
         1:       v = seed + i;
         2:       v = ~a;
         default: v = a * SCALE;
      endcase
      return v[DW-1:0];
   endfunction

   task automatic scramble_cfg();
      bus.cfg_base   = AW'($urandom);
      bus.cfg_stride = AW'($urandom);
      bus.cfg_len    = LW'($urandom_range(1, 9));
      bus.cfg_mode   = mode_t'($urandom_range(3));
      bus.cfg_seed   = DW'($urandom);
   endtask

   // Drives one burst and records what the slave side sees; rdy_kind 0=random pct, 1=1,0,0 pattern, 2=never ready.
   task automatic run_burst(input int base, input int stride, input int len, input int mode, input int seed,
                            input int rdy_kind, input int pct, input int poke_at);
      bit r, prev_stall;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      obs_a.delete(); obs_d.delete();
      stall_bad = 0; busy_bad = 0; done_lat = -1; first_v = -1; first_x = -1; last_x = -1;
      vld_cycles = 0; done_seen = 0; to_seen = 0; prev_stall = 0; pa = '0; pd = '0;
      @(negedge clk);
      bus.cfg_base = base[AW-1:0]; bus.cfg_stride = stride[AW-1:0]; bus.cfg_len = len[LW-1:0];
      bus.cfg_mode = mode_t'(mode[1:0]); bus.cfg_seed = seed[DW-1:0];
      bus.start = 1'b1; bus.sready = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      scramble_cfg();
      for (int k = 1; k <= 600; k++) begin
         if (prev_stall && !bus.done && !(bus.valid && bus.addr == pa && bus.data == pd)) stall_bad++;
         if (bus.valid && !bus.busy) busy_bad++;
         if (bus.done && bus.busy) busy_bad++;
         if (bus.valid) begin
            vld_cycles++;
            if (first_v < 0) first_v = k;
         end
         if (bus.done) begin
            done_seen = 1;
`ifdef MS_BURST_STALL_TIMEOUT_EN
            to_seen = bus.timeout;
`endif
            done_lat = (last_x < 0) ? k : k - last_x;
            break;
         end
         if (k == poke_at) begin bus.start = 1'b1; scramble_cfg(); end
         else bus.start = 1'b0;
         case (rdy_kind)
            0:       r = ($urandom_range(99) < pct);
            1:       r = ((k - 1) % 3 == 0);
            default: r = 1'b0;
         endcase
         bus.sready = r;
         if (bus.valid && r) begin
            obs_a.push_back(bus.addr); obs_d.push_back(bus.data);
            if (first_x < 0) first_x = k;
            last_x = k;
         end
         prev_stall = bus.valid && !r;
         pa = bus.addr; pd = bus.data;
         @(negedge clk);
      end
      bus.start = 1'b0; bus.sready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      #1 rstn = 1'b0;
      #1;
      n_chk++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
      n_chk++; if (bus.addr  !== '0)   begin n_fail++; $display("FAIL reset_addr got %h exp 0", bus.addr); end
      n_chk++; if (bus.data  !== '0)   begin n_fail++; $display("FAIL reset_data got %h exp 0", bus.data); end
      n_chk++; if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      n_chk++; if (bus.done  !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_basic();
      run_burst('h10, 1, 4, 0, 0, 0, 100, 0);
      n_chk++; if (obs_a.size() !== 4) begin n_fail++; $display("FAIL basic_count got %0d exp 4", obs_a.size()); end
      for (int i = 0; i < obs_a.size(); i++) begin
         n_chk++; if (obs_a[i] !== ref_addr('h10, 1, i)) begin n_fail++; $display("FAIL basic_addr[%0d] got %h exp %h", i, obs_a[i], ref_addr('h10, 1, i)); end
         n_chk++; if (obs_d[i] !== ref_data(0, ref_addr('h10, 1, i), 0, i)) begin n_fail++; $display("FAIL basic_data[%0d] got %h exp %h", i, obs_d[i], ref_data(0, ref_addr('h10, 1, i), 0, i)); end
      end
      n_chk++; if (first_v !== 1) begin n_fail++; $display("FAIL basic_start_latency got %0d exp 1", first_v); end
      n_chk++; if (last_x - first_x + 1 !== 4) begin n_fail++; $display("FAIL basic_back_to_back span got %0d exp 4", last_x - first_x + 1); end
      n_chk++; if (done_lat !== 1) begin n_fail++; $display("FAIL basic_done_latency got %0d exp 1", done_lat); end
      n_chk++; if (busy_bad !== 0) begin n_fail++; $display("FAIL basic_busy got %0d bad cycles exp 0", busy_bad); end
      @(negedge clk);
      n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b exp 0", bus.done); end
   endtask

   task automatic test_backpressure();
      run_burst('h20, 3, 3, 1, 'h100, 1, 0, 0);
      n_chk++; if (obs_d.size() !== 3) begin n_fail++; $display("FAIL bp_count got %0d exp 3", obs_d.size()); end
      for (int i = 0; i < obs_d.size(); i++) begin
         n_chk++; if (obs_d[i] !== ref_data(1, 0, 'h100, i)) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp %h", i, obs_d[i], ref_data(1, 0, 'h100, i)); end
      end
      n_chk++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stall_hold got %0d bad cycles exp 0", stall_bad); end
      n_chk++; if (done_lat !== 1) begin n_fail++; $display("FAIL bp_done_latency got %0d exp 1", done_lat); end
   endtask

   task automatic test_wrap();
      run_burst('hFE, 2, 3, 2, int'($urandom), 0, 100, 0);
      n_chk++; if (obs_a.size() !== 3) begin n_fail++; $display("FAIL wrap_count got %0d exp 3", obs_a.size()); end
      for (int i = 0; i < obs_a.size(); i++) begin
         n_chk++; if (obs_a[i] !== ref_addr('hFE, 2, i)) begin n_fail++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, obs_a[i], ref_addr('hFE, 2, i)); end
         n_chk++; if (obs_d[i] !== ref_data(2, ref_addr('hFE, 2, i), 0, i)) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", i, obs_d[i], ref_data(2, ref_addr('hFE, 2, i), 0, i)); end
      end
   endtask

   task automatic test_zero_len();
      run_burst(int'($urandom), 1, 0, 0, 0, 0, 100, 0);
      n_chk++; if (vld_cycles !== 0) begin n_fail++; $display("FAIL zero_valid got %0d valid cycles exp 0", vld_cycles); end
      n_chk++; if (done_lat !== 1) begin n_fail++; $display("FAIL zero_done_latency got %0d exp 1", done_lat); end
      // start while done is high must be dropped
      bus.cfg_len = 8'd3; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_chk++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL finish_start_ignored got valid=%b busy=%b exp 0 0", bus.valid, bus.busy); end
      n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width got %b exp 0", bus.done); end
   endtask

   task automatic test_ignored_start();
      int b, s;
      b = int'($urandom); s = int'($urandom);
      run_burst(b, s, 6, 0, 0, 0, 60, 3);
      n_chk++; if (obs_a.size() !== 6) begin n_fail++; $display("FAIL midstart_count got %0d exp 6", obs_a.size()); end
      for (int i = 0; i < obs_a.size(); i++) begin
         n_chk++; if (obs_a[i] !== ref_addr(b, s, i)) begin n_fail++; $display("FAIL midstart_addr[%0d] got %h exp %h", i, obs_a[i], ref_addr(b, s, i)); end
      end
   endtask

   task automatic test_reset_mid();
      int b;
      b = int'($urandom_range(255));
      @(negedge clk);
      bus.cfg_base = b[AW-1:0]; bus.cfg_stride = 8'd1; bus.cfg_len = 8'd5;
      bus.cfg_mode = PAT_SCALE; bus.start = 1'b1; bus.sready = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      n_chk++; if ({bus.valid, bus.busy, bus.done} !== 3'b000 || bus.addr !== '0 || bus.data !== '0) begin
         n_fail++; $display("FAIL reset_mid_async got v=%b b=%b d=%b a=%h dt=%h exp all 0", bus.valid, bus.busy, bus.done, bus.addr, bus.data);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_done got %b exp 0", bus.done); end
      end
      rstn = 1'b1; bus.sready = 1'b0;
      run_burst(b, 1, 5, 0, 0, 0, 100, 0);
      n_chk++; if (obs_a.size() !== 5) begin n_fail++; $display("FAIL reset_mid_rerun_count got %0d exp 5", obs_a.size()); end
      n_chk++; if (obs_a.size() > 0 && obs_a[0] !== ref_addr(b, 1, 0)) begin n_fail++; $display("FAIL reset_mid_rerun_addr got %h exp %h", obs_a[0], ref_addr(b, 1, 0)); end
   endtask

   task automatic test_random();
      int b, s, l, m, sd, p;
      for (int it = 0; it < 25; it++) begin
         b = int'($urandom); s = int'($urandom); l = int'($urandom_range(0, 10));
         m = int'($urandom_range(3)); sd = int'($urandom); p = int'($urandom_range(50, 100));
         run_burst(b, s, l, m, sd, 0, p, (it % 3 == 0) ? 2 : 0);
         n_chk++; if (obs_a.size() !== l) begin n_fail++; $display("FAIL rand%0d_count got %0d exp %0d", it, obs_a.size(), l); end
         for (int i = 0; i < obs_a.size(); i++) begin
            n_chk++;
            if (obs_a[i] !== ref_addr(b, s, i) || obs_d[i] !== ref_data(m, ref_addr(b, s, i), sd, i)) begin
               n_fail++; $display("FAIL rand%0d_beat%0d got %h/%h exp %h/%h", it, i, obs_a[i], obs_d[i], ref_addr(b, s, i), ref_data(m, ref_addr(b, s, i), sd, i));
            end
         end
         n_chk++; if (stall_bad !== 0 || busy_bad !== 0) begin n_fail++; $display("FAIL rand%0d_protocol got stall=%0d busy=%0d exp 0 0", it, stall_bad, busy_bad); end
         n_chk++; if (done_lat !== 1) begin n_fail++; $display("FAIL rand%0d_done_latency got %0d exp 1", it, done_lat); end
`ifdef MS_BURST_STALL_TIMEOUT_EN
         n_chk++; if (to_seen !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout got %b exp 0", it, to_seen); end
`endif
      end
   endtask

`ifdef MS_BURST_STALL_TIMEOUT_EN
   task automatic test_timeout();
      run_burst(int'($urandom), 1, 4, 0, 0, 2, 0, 0);
      n_chk++; if (!done_seen) begin n_fail++; $display("FAIL timeout_done got none exp pulse"); end
      n_chk++; if (to_seen !== 1'b1) begin n_fail++; $display("FAIL timeout_flag got %b exp 1", to_seen); end
      n_chk++; if (vld_cycles !== TO_CYC) begin n_fail++; $display("FAIL timeout_stall_cycles got %0d exp %0d", vld_cycles, TO_CYC); end
      n_chk++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL timeout_valid got %b exp 0", bus.valid); end
      @(negedge clk);
      n_chk++; if (bus.timeout !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL timeout_width got to=%b done=%b exp 0 0", bus.timeout, bus.done); end
   endtask
`endif

   initial begin
      bus.start = 1'b0; bus.sready = 1'b0; bus.cfg_base = '0; bus.cfg_stride = '0;
      bus.cfg_len = '0; bus.cfg_mode = PAT_SCALE; bus.cfg_seed = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_ignored_start();
      test_reset_mid();
      test_random();
`ifdef MS_BURST_STALL_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ms_burst_master.md
Name: ms_burst_master

Overview:
- Parametrised successor of the single-beat address/data master.
- On a start pulse it issues a programmed burst of address/data beats to a slave over a valid/ready handshake.
- Address starts at a programmable base, advances by a programmable stride, and wraps.
- Data comes from a selectable pattern generator.
- Sits between a test/config controller and any slave exposing a ready output.

Parameters:
- AW, 8, address width in bits.
- DW, 16, data width in bits.
- LW, 8, burst-length counter width; max burst 2**LW-1 beats.
- SCALE, 4, multiplier used by pattern mode 0.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- cfg_base  input  AW  first beat address.
- cfg_stride  input  AW  address increment per beat.
- cfg_len  input  LW  number of beats.
- cfg_mode  input  2  data pattern select.
- cfg_seed  input  DW  seed for mode 1.
- valid  output  1  beat presented.
- sready  input  1  slave accepts beat.
- addr  output  AW  beat address.
- data  output  DW  beat data.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse, burst complete.

Behaviour:
- Reset:
  - Asynchronous assert, synchronous deassert handled upstream.
  - valid=0, addr=0, data=0, busy=0, done=0, state=IDLE, beat counter=0.
  - Reset mid-burst aborts immediately; no done pulse.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start=1 with cfg_len!=0 latches all cfg_* inputs and moves to RUN.
  - On the next edge: valid=1, addr=cfg_base, data=pattern(beat 0), busy=1.
  - start=1 with cfg_len==0 moves to FINISH; no beats issued.
  - All cfg_* inputs are ignored outside this capture.
- RUN:
  - A beat transfers on any edge with valid&&sready.
  - While valid&&!sready, addr and data are held stable and valid stays 1. valid never drops before transfer.
  - On a transfer, if it was not the last beat:
    - addr <= addr+stride, modulo 2**AW; wrap is silent.
    - data <= pattern(next beat); beat counter increments.
    - Back-to-back transfers sustain 1 beat/cycle.
  - On transfer of the last beat: valid<=0, move to FINISH.
- FINISH:
  - done=1 for exactly one cycle; busy=0 in the same cycle.
  - Return to IDLE.
  - start in FINISH is ignored.
  - Earliest new start is sampled the cycle after done.
- start while busy is ignored; no queueing.
- Data patterns, all results truncated to DW:
  - mode 0: zero-extended addr * SCALE.
  - mode 1: seed + beat index; beat 0 = seed.
  - mode 2: bitwise inverse of zero-extended addr.
  - mode 3: reserved, behaves as mode 0.
- Latency: start to first valid = 1 cycle; last transfer to done = 1 cycle.
- sready is don't-care when valid=0.

Optional Feature:
- Macro MS_BURST_STALL_TIMEOUT_EN.
- When defined:
  - Add output timeout (1 bit) and parameter TO_CYC (default 16).
  - A stall counter counts consecutive RUN cycles with valid&&!sready and clears on any transfer.
  - When the count reaches TO_CYC: abort the burst, valid<=0, go to FINISH.
  - done and timeout pulse together for one cycle.
- When undefined:
  - No port or counter exists.
  - The master waits indefinitely for sready.

Decomposition:
- Package ms_burst_pkg holds:
  - typedef enum state_t {IDLE, RUN, FINISH}.
  - typedef enum logic [1:0] mode_t {PAT_SCALE, PAT_SEQ, PAT_INV, PAT_RSVD}.
  - Default localparams for AW/DW/LW/SCALE.
- One sub-module, ms_pattern_gen: combinational function of mode, addr, seed and beat index producing DW data.
- FSM, address and counters stay in ms_burst_master.

Test Plan:
- Basic burst, sready tied 1: base=0x10, stride=1, len=4, mode0. Expect addr 0x10..0x13 and data 0x40,0x44,0x48,0x4C on 4 consecutive cycles; done 1 cycle after the last beat.
- Backpressure: sready toggling 1,0,0,1,... with len=3, mode1, seed=0x100. Expect data 0x100,0x101,0x102; addr/data unchanged during every stall; exactly 3 transfers.
- Wrap: AW=8, base=0xFE, stride=2, len=3. Expect addr 0xFE, 0x00, 0x02; mode2 data 0xFF01, 0xFFFF, 0xFFFD.
- Zero length and ignored start: len=0 gives done pulse 1 cycle later with valid never asserted; start pulsed mid-burst does not alter the beat count.
- Reset mid-burst: assert rstn=0 after beat 2 of 5. All outputs go to 0 immediately without waiting for clk; no done pulse; a fresh start after release runs a full 5-beat burst.
- Timeout (MS_BURST_STALL_TIMEOUT_EN, TO_CYC=16): sready held 0. Expect done and timeout both pulse on the same cycle after 16 stalled cycles; valid then 0.
